// File: rtl/perf_event_monitor.sv
// Performance monitor: counts cycles and per-channel events while the CPU runs,
// freezes on halt or watchdog expiry, then streams every counter over a valid/ready port.
module perf_event_monitor #(
  parameter int unsigned NUM_EVENTS  = 4,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter bit          SATURATE    = 1'b1,
  parameter int unsigned CYCLE_LIMIT = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_EVENTS-1:0] event_in,
  input  logic                  hlt,
  input  logic                  clear,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [3:0]            dump_idx,
  output logic [CNT_WIDTH-1:0]  dump_data,
  output logic                  dump_done,
  output logic                  timeout,
  output logic                  running
);

  // state  | meaning
  // IDLE   | waiting for start, nothing counted
  // RUN    | cycle and event counters advancing
  // FROZEN | one-cycle pause after halt/timeout, counters held
  // DUMP   | presenting counter[dump_idx] on the dump port
  // DONE   | all words transferred, waiting for start
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_FROZEN = 3'd2,
    S_DUMP   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // A limit that does not fit in CNT_WIDTH bits can never be reached.
  localparam bit LIMIT_EN = (CYCLE_LIMIT != 0) &&
                            ((64'(CYCLE_LIMIT) >> CNT_WIDTH) == 64'd0);
  localparam logic [CNT_WIDTH-1:0] LIMIT_VAL = CNT_WIDTH'(CYCLE_LIMIT);
  localparam logic [3:0] LAST_IDX = 4'(NUM_EVENTS);

  state_t                 state_q, state_d;
  logic [3:0]             idx_q, idx_d;
  logic                   timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0]   cnt_q [0:NUM_EVENTS];
  logic [CNT_WIDTH-1:0]   cnt_d [0:NUM_EVENTS];
  logic [CNT_WIDTH-1:0]   cyc_inc;

  function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) return SATURATE ? v : '0;
    return v + CNT_WIDTH'(1);
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    cyc_inc   = cnt_inc(cnt_q[0]);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_RUN;
          idx_d     = '0;
          timeout_d = 1'b0;
          cnt_d     = '{default: '0};
        end
      end
      S_RUN: begin
        cnt_d[0] = cyc_inc;
        for (int k = 0; k < NUM_EVENTS; k++) begin
          if (event_in[k]) cnt_d[k+1] = cnt_inc(cnt_q[k+1]);
        end
        // halt wins over a coincident watchdog hit
        if (hlt) begin
          state_d = S_FROZEN;
        end else if (LIMIT_EN && !clear && (cyc_inc == LIMIT_VAL)) begin
          state_d   = S_FROZEN;
          timeout_d = 1'b1;
        end
      end
      S_FROZEN: begin
        state_d = S_DUMP;
        idx_d   = '0;
      end
      S_DUMP: begin
        if (dump_ready) begin
          if (idx_q == LAST_IDX) state_d = S_DONE;
          else                   idx_d   = idx_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // clear discards this cycle's increments and never touches state
    if (clear) cnt_d = '{default: '0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    dump_data = '0;
    if (state_q == S_DUMP) begin
      for (int k = 0; k <= NUM_EVENTS; k++) begin
        if (idx_q == 4'(k)) dump_data = cnt_q[k];
      end
    end
  end

  assign dump_valid = (state_q == S_DUMP);
  assign dump_idx   = idx_q;
  assign dump_done  = (state_q == S_DONE);
  assign timeout    = timeout_q;
  assign running    = (state_q == S_RUN);

endmodule
